// File: rtl/ring_decoder.sv
// ring_decoder: receive-side checker/decoder for a one-hot ring code.
// Tracks a ring that advances one position per valid sample. It acquires lock
// after LOCK_CNT consecutive correct successors and decodes the code to a
// binary index. It also flags wrap-around and sequence errors.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   ring_in   N-bit one-hot ring code sample
//   ring_vld  sample strobe (samples with ring_vld=0 are ignored)
//   index     binary position of the last accepted locked sample
//   index_vld one-cycle pulse, index updated
//   locked    level, decoder is tracking
//   wrap      one-cycle pulse, index advanced N-1 -> 0
//   err       one-cycle pulse, sequence error while locked
//   err_cnt   saturating error count (constant 0 unless the macro is defined)
//
// Optional feature: define RING_DEC_ERRCNT_EN to build the err_cnt counter.
module ring_decoder #(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 2,
  parameter  int ECW      = 8,
  localparam int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   ring_in,
  input  logic           ring_vld,
  output logic [W-1:0]   index,
  output logic           index_vld,
  output logic           locked,
  output logic           wrap,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {S_SEARCH, S_ACQ, S_LOCKED} state_t;

  state_t        state, state_n;
  logic [W-1:0]  prev_idx, prev_n, index_n, idx_c, succ;
  logic [RW-1:0] run, run_n;
  logic [RW:0]   run_inc;
  logic          onehot, is_succ, at_end;
  logic          ivld_n, wrap_n, err_n;

  // Decode: position of the set bit (only meaningful when onehot).
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < N; i++)
      if (ring_in[i]) idx_c = W'(i);
  end

  assign onehot  = $onehot(ring_in);
  assign at_end  = (prev_idx == W'(N - 1));
  assign succ    = at_end ? '0 : prev_idx + 1'b1;
  assign is_succ = onehot && (idx_c == succ);
  assign run_inc = {1'b0, run} + 1'b1;
  assign locked  = (state == S_LOCKED);

  always_comb begin
    state_n = state;
    prev_n  = prev_idx;
    run_n   = run;
    index_n = index;
    ivld_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    if (ring_vld) begin
      case (state)
        S_SEARCH: begin
          if (onehot) begin
            prev_n  = idx_c;
            run_n   = '0;
            state_n = S_ACQ;
          end
        end
        S_ACQ: begin
          if (is_succ) begin
            prev_n = idx_c;
            run_n  = RW'(run_inc);
            if (run_inc == (RW + 1)'(LOCK_CNT)) begin
              state_n = S_LOCKED;
              index_n = idx_c;
              ivld_n  = 1'b1;
              wrap_n  = at_end;
            end
          end else if (onehot) begin
            // Wrong step but a valid code: reseed from this sample.
            prev_n = idx_c;
            run_n  = '0;
          end else begin
            state_n = S_SEARCH;
          end
        end
        S_LOCKED: begin
          if (is_succ) begin
            index_n = idx_c;
            prev_n  = idx_c;
            ivld_n  = 1'b1;
            wrap_n  = at_end;
          end else begin
            // The offending sample is discarded; the next one seeds SEARCH.
            err_n   = 1'b1;
            state_n = S_SEARCH;
          end
        end
        default: state_n = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SEARCH;
      prev_idx  <= '0;
      run       <= '0;
      index     <= '0;
      index_vld <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      prev_idx  <= prev_n;
      run       <= run_n;
      index     <= index_n;
      index_vld <= ivld_n;
      wrap      <= wrap_n;
      err       <= err_n;
    end
  end

`ifdef RING_DEC_ERRCNT_EN
  logic [ECW-1:0] ec_q;
  always_ff @(posedge clk) begin
    if (rst)                    ec_q <= '0;
    else if (err_n && ec_q != '1) ec_q <= ec_q + 1'b1;
  end
  assign err_cnt = ec_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder (N=4, LOCK_CNT=2, ECW=8).
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ring_in;
  logic       ring_vld;
  logic [1:0] index;
  logic       index_vld, locked, wrap, err;
  logic [7:0] err_cnt;

  int ntests = 0;
  int nfail  = 0;
  int nerr   = 0;  // errors the bench expects the DUT to have counted
  int npulse = 0;

  ring_decoder #(.N(4), .LOCK_CNT(2), .ECW(8)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
    .index(index), .index_vld(index_vld), .locked(locked),
    .wrap(wrap), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int ec_exp(input int n);
`ifdef RING_DEC_ERRCNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check every output; err_cnt expectation comes from the bench's error tally.
  task automatic chk_all(input string tag, input int idx, input bit iv,
                         input bit lk, input bit wr, input bit er);
    chk({tag, ".index"},     32'(index),     32'(idx));
    chk({tag, ".index_vld"}, 32'(index_vld), 32'(iv));
    chk({tag, ".locked"},    32'(locked),    32'(lk));
    chk({tag, ".wrap"},      32'(wrap),      32'(wr));
    chk({tag, ".err"},       32'(err),       32'(er));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(ec_exp(nerr)));
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising edge.
  task automatic cyc(input logic [3:0] r, input logic v);
    @(negedge clk);
    ring_in  = r;
    ring_vld = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ring_in = 4'b0110; ring_vld = 1'b1;
    cyc(4'b0110, 1'b1);
    cyc(4'b0001, 1'b1);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Non-one-hot in SEARCH: ignored, no err.
    cyc(4'b0011, 1'b1); chk_all("search_bad", 0, 0, 0, 0, 0);

    // Clean lock and run through a wrap.
    cyc(4'b0001, 1'b1); chk_all("lk1", 0, 0, 0, 0, 0);
    cyc(4'b0010, 1'b1); chk_all("lk2", 0, 0, 0, 0, 0);
    cyc(4'b0100, 1'b1); chk_all("lk3", 2, 1, 1, 0, 0);
    cyc(4'b1000, 1'b1); chk_all("run3", 3, 1, 1, 0, 0);
    cyc(4'b0001, 1'b1); chk_all("wrap0", 0, 1, 1, 1, 0);
    cyc(4'b0010, 1'b1); chk_all("run1", 1, 1, 1, 0, 0);

    // Non-one-hot while locked at 1.
    nerr++;
    cyc(4'b0110, 1'b1); chk_all("err_nh", 1, 0, 0, 0, 1);
    cyc(4'b0001, 1'b1); chk_all("err_nh_seed", 1, 0, 0, 0, 0);
    cyc(4'b0010, 1'b1); chk_all("err_nh_acq", 1, 0, 0, 0, 0);
    cyc(4'b0100, 1'b1); chk_all("err_nh_relock", 2, 1, 1, 0, 0);

    // Skip from index 1 to 3.
    cyc(4'b1000, 1'b1);
    cyc(4'b0001, 1'b1);
    cyc(4'b0010, 1'b1); chk_all("pre_skip", 1, 1, 1, 0, 0);
    nerr++;
    cyc(4'b1000, 1'b1); chk_all("err_skip", 1, 0, 0, 0, 1);
    cyc(4'b0001, 1'b1); chk_all("skip_acq", 1, 0, 0, 0, 0);
    cyc(4'b0010, 1'b1); chk_all("skip_acq2", 1, 0, 0, 0, 0);
    cyc(4'b0100, 1'b1); chk_all("skip_relock", 2, 1, 1, 0, 0);

    // ring_vld=0 with garbage: everything holds.
    cyc(4'b0110, 1'b0); chk_all("idle0", 2, 0, 1, 0, 0);
    cyc(4'b1111, 1'b0); chk_all("idle1", 2, 0, 1, 0, 0);
    cyc(4'b0000, 1'b0); chk_all("idle2", 2, 0, 1, 0, 0);
    cyc(4'b0100, 1'b0); chk_all("idle3", 2, 0, 1, 0, 0);
    cyc(4'b0001, 1'b0); chk_all("idle4", 2, 0, 1, 0, 0);
    cyc(4'b1000, 1'b1); chk_all("resume", 3, 1, 1, 0, 0);

    // Reset mid-lock at index 3 with two errors counted.
    @(negedge clk); rst = 1'b1; ring_in = 4'b0001; ring_vld = 1'b1;
    @(posedge clk); #1;
    nerr = 0;
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(4'b0001, 1'b1); chk_all("rl1", 0, 0, 0, 0, 0);
    cyc(4'b0010, 1'b1); chk_all("rl2", 0, 0, 0, 0, 0);
    cyc(4'b0100, 1'b1); chk_all("rl3", 2, 1, 1, 0, 0);

    // Repeat sample error, then ACQUIRE restart and lock coinciding with a wrap.
    nerr++;
    cyc(4'b0100, 1'b1); chk_all("err_rep", 2, 0, 0, 0, 1);
    cyc(4'b0001, 1'b1); chk_all("acq_seed", 2, 0, 0, 0, 0);
    cyc(4'b0100, 1'b1); chk_all("acq_restart", 2, 0, 0, 0, 0);
    cyc(4'b1000, 1'b1); chk_all("acq_run1", 2, 0, 0, 0, 0);
    cyc(4'b0001, 1'b1); chk_all("lock_wrap", 0, 1, 1, 1, 0);

    // Backward step while locked at 0.
    nerr++;
    cyc(4'b1000, 1'b1); chk_all("err_back", 0, 0, 0, 0, 1);

    // Non-one-hot during ACQUIRE drops back to SEARCH, no err.
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1); chk_all("acq_nh", 0, 0, 0, 0, 0);
    cyc(4'b0010, 1'b1);
    cyc(4'b0100, 1'b1); chk_all("acq_nh_notyet", 0, 0, 0, 0, 0);
    cyc(4'b1000, 1'b1); chk_all("acq_nh_lock", 3, 1, 1, 0, 0);

    // Saturation: 300 forced errors, each followed by a relock.
    for (int i = 0; i < 300; i++) begin
      cyc(4'b0000, 1'b1);
      nerr++;
      if (err) npulse++;
      cyc(4'b0001, 1'b1);
      cyc(4'b0010, 1'b1);
      cyc(4'b0100, 1'b1);
    end
    chk("sat_pulses", 32'(npulse), 32'd300);
    chk_all("sat_final", 2, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
